// File: rtl/ca_pkg.sv
// Shared definitions for the binary cellular automaton: neighbourhood width,
// rule type and named Wolfram rules.
package ca_pkg;

    // A radius-1 neighbourhood is left, self and right.
    localparam int NBHD_W = 3;

    // Wolfram rule table: bit k is the next cell value for neighbourhood code k.
    typedef logic [7:0] rule_t;

    localparam rule_t RULE30  = 8'h1E;
    localparam rule_t RULE60  = 8'h3C;
    localparam rule_t RULE90  = 8'h5A;
    localparam rule_t RULE150 = 8'h96;

endpackage : ca_pkg

// File: rtl/ca_cell.sv
// Single automaton cell: a pure lookup of the rule table by the 3-bit
// neighbourhood code {left, self, right}, left neighbour as MSB.
module ca_cell
    import ca_pkg::*;
(
    input  logic  left,
    input  logic  self,
    input  logic  right,
    input  rule_t rule,
    output logic  next
);

    logic [NBHD_W-1:0] code;

    // Form the neighbourhood code and index the rule table with it.
    always_comb begin
        code = {left, self, right};
        next = rule[code];
    end

endmodule : ca_cell

// File: rtl/binary_cellular_automata_2d.sv
// Width-cell, one-dimensional, binary cellular automaton with a radius-1
// neighbourhood and a parameterised Wolfram rule. The seed on `set` is loaded
// on the first enabled edge after reset; every later enabled edge advances
// one generation. All cells update together from the registered state.
//
// Build option: define BCA_NULL_BOUNDARY_EN to make cells beyond either edge
// read as constant 0; otherwise the cell array wraps around cyclically.
module binary_cellular_automata_2d
    import ca_pkg::*;
#(
    parameter int    Width = 16,
    parameter rule_t Rule  = RULE30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [Width-1:0] set,
    output logic [Width-1:0] state
);

    // Cell i reads its left neighbour from i+1 and its right neighbour from i-1.
    logic [Width-1:0] left_nb;
    logic [Width-1:0] right_nb;
    logic [Width-1:0] state_next;
    logic             load_pending_reg;

`ifdef BCA_NULL_BOUNDARY_EN
    // Null boundary: the virtual cells past the MSB and LSB are constant 0.
    assign left_nb  = {1'b0, state[Width-1:1]};
    assign right_nb = {state[Width-2:0], 1'b0};
`else
    // Cyclic boundary: the MSB's left neighbour is cell 0 and vice versa.
    assign left_nb  = {state[0], state[Width-1:1]};
    assign right_nb = {state[Width-2:0], state[Width-1]};
`endif

    // One rule lookup per cell; all read the old state, so there is no ripple.
    generate
        for (genvar gi = 0; gi < Width; gi++) begin : g_cell
            ca_cell u_cell (
                .left  (left_nb[gi]),
                .self  (state[gi]),
                .right (right_nb[gi]),
                .rule  (Rule),
                .next  (state_next[gi])
            );
        end
    endgenerate

    // State register: async clear arms a seed load, first enabled edge loads
    // the live value of set, later enabled edges step one generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= '0;
            load_pending_reg <= 1'b1;
        end else if (ce) begin
            if (load_pending_reg) begin
                state            <= set;
                load_pending_reg <= 1'b0;
            end else begin
                state <= state_next;
            end
        end
    end

endmodule : binary_cellular_automata_2d

// File: tb/tb_binary_cellular_automata_2d.sv
// Directed bench for binary_cellular_automata_2d: four parallel instances
// (rules 30/60/90/150) sharing set/rst/ce, plus a four-instance migration ring.
module tb_binary_cellular_automata_2d;
    import ca_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         ce;
    logic [W-1:0] set;
    logic [W-1:0] st30, st60, st90, st150;
    logic [W-1:0] ring [4];

    int checks;
    int errors;

    binary_cellular_automata_2d #(.Width(W), .Rule(RULE30)) u30 (
        .clk(clk), .rst(rst), .ce(ce), .set(set), .state(st30));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE60)) u60 (
        .clk(clk), .rst(rst), .ce(ce), .set(set), .state(st60));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE90)) u90 (
        .clk(clk), .rst(rst), .ce(ce), .set(set), .state(st90));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE150)) u150 (
        .clk(clk), .rst(rst), .ce(ce), .set(set), .state(st150));

    // Ring: each instance is seeded from the next instance's state.
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE30)) ur0 (
        .clk(clk), .rst(rst), .ce(ce), .set(ring[1]), .state(ring[0]));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE60)) ur1 (
        .clk(clk), .rst(rst), .ce(ce), .set(ring[2]), .state(ring[1]));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE90)) ur2 (
        .clk(clk), .rst(rst), .ce(ce), .set(ring[3]), .state(ring[2]));
    binary_cellular_automata_2d #(.Width(W), .Rule(RULE150)) ur3 (
        .clk(clk), .rst(rst), .ce(ce), .set(ring[0]), .state(ring[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] seed;
        logic [W-1:0] exp30;
        logic [W-1:0] exp60;
        logic [W-1:0] exp90;
        logic [W-1:0] exp150;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse between edges, then load `seed` on the next enabled edge.
    task automatic reset_and_load(input logic [W-1:0] seed);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        set = seed;
        ce  = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h0100, 16'h0380, 16'h0180, 16'h0280, 16'h0380};
`ifdef BCA_NULL_BOUNDARY_EN
        vecs[1] = '{16'h0001, 16'h0003, 16'h0001, 16'h0002, 16'h0003};
        vecs[2] = '{16'h8000, 16'hC000, 16'hC000, 16'h4000, 16'hC000};
`else
        vecs[1] = '{16'h0001, 16'h8003, 16'h8001, 16'h8002, 16'h8003};
        vecs[2] = '{16'h8000, 16'hC001, 16'hC000, 16'h4001, 16'hC001};
`endif

        // Asynchronous reset, asserted before the first clock edge.
        rst = 1'b1;
        ce  = 1'b0;
        set = '0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", st30, 16'h0000);

        // Release and load a seed, then hold with ce=0.
        #1;
        rst = 1'b1;
        set = 16'h1234;
        ce  = 1'b1;
        tick();
        check("seed_load_r30", st30, 16'h1234);
        check("seed_load_r150", st150, 16'h1234);
        ce = 1'b0;
        tick();
        check("hold_ce0", st30, 16'h1234);

        // Single-step table across the four rules.
        for (int i = 0; i < 3; i++) begin
            reset_and_load(vecs[i].seed);
            check($sformatf("v%0d_load", i), st90, vecs[i].seed);
            tick();
            check($sformatf("v%0d_rule30", i), st30, vecs[i].exp30);
            check($sformatf("v%0d_rule60", i), st60, vecs[i].exp60);
            check($sformatf("v%0d_rule90", i), st90, vecs[i].exp90);
            check($sformatf("v%0d_rule150", i), st150, vecs[i].exp150);
        end

        // Clock enable: three idle edges hold, one enabled edge steps once.
        reset_and_load(16'h0100);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ce_hold%0d", i), st90, 16'h0100);
        end
        ce = 1'b1;
        tick();
        check("ce_step1", st90, 16'h0280);
        tick();
        check("ce_step2", st90, 16'h0440);

        // Reset mid-run: five generations, async clear, reload live set.
        reset_and_load(16'h0001);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        check("midrun_clear_r30", st30, 16'h0000);
        check("midrun_clear_r60", st60, 16'h0000);
        set = 16'hBEEF;
        #1;
        rst = 1'b1;
        tick();
        check("midrun_reload", st30, 16'hBEEF);
        // set is ignored after the load edge; rule60 is left XOR self.
        set = 16'h0000;
        tick();
`ifdef BCA_NULL_BOUNDARY_EN
        check("post_reload_r60", st60, 16'hE198);
`else
        check("post_reload_r60", st60, 16'h6198);
`endif

        // Ring migration: run, reset, one enabled edge loads neighbour state (0).
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ring%0d_value", i), ring[i], 16'h0000);
            checks++;
            if ($isunknown(ring[i])) begin
                errors++;
                $display("FAIL ring%0d_no_x: got %b expected no X/Z bits", i, ring[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_binary_cellular_automata_2d
